fifo_drain_packer: RTL and testbench
====================================

Name: fifo_drain_packer

Overview:
- Downstream consumer of the single-clock synchronous FIFO.
- Pops IN_WIDTH-bit words from the FIFO's head using its active-low pop request and empty flag, and packs RATIO consecutive words into one wide word.
- Presents the wide word on a valid/ready output with a registered output slice.
- Supports a flush that emits a partial word. Sits between the ingress FIFO and the wide datapath.

Parameters:
IN_WIDTH, 8, width of one FIFO word (matches the FIFO width)
RATIO, 4, FIFO words per output word, >=2
LSB_FIRST, 1, 1: first popped word occupies out_data[IN_WIDTH-1:0]; 0: first word occupies the MS lane

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
fifo_empty  in  1  FIFO empty flag
fifo_data  in  IN_WIDTH  FIFO head word (data_out), valid when fifo_empty=0
fifo_pop_req_n  out  1  active-low pop request to the FIFO
flush  in  1  single-cycle request to emit any partial word
out_valid  out  1  out_data/out_count valid
out_ready  in  1  downstream accepts when out_valid&out_ready
out_data  out  IN_WIDTH*RATIO  packed word
out_count  out  $clog2(RATIO+1)  number of valid lanes: RATIO for a full word, 1..RATIO-1 for a flushed word

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_count=0.
  - Lane counter cnt=0, accumulator=0, state=FILL.
  - fifo_pop_req_n=1 while rst is high.
- Output slot: free = !out_valid || out_ready.
- Pop rule (combinational): pop = state==FILL && !fifo_empty && (cnt<RATIO-1 || free). fifo_pop_req_n = ~pop.
  - Pop is never asserted while fifo_empty=1, so no FIFO underflow error is ever caused.
- Pop with cnt<RATIO-1:
  - fifo_data is written into lane cnt (lane mapping per LSB_FIRST).
  - cnt increments.
- Pop with cnt==RATIO-1:
  - Accumulator plus fifo_data are loaded into out_data; out_count=RATIO; out_valid=1 on the next edge.
  - cnt returns to 0 and the accumulator clears.
- Latency: out_valid rises the cycle after the edge that pops the RATIO-th word.
- Throughput: one pop per cycle sustained while the FIFO is non-empty and out_ready=1, giving one output word every RATIO cycles.
- Output handshake:
  - out_valid&out_ready with no new load: out_valid falls next edge.
  - Load and accept in the same cycle: out_valid stays 1 with the new data.
  - out_data and out_count hold stable while out_valid=1 && out_ready=0.
- States:
  - FILL: normal packing.
  - FLUSH: partial word is waiting for a free output slot; pops are suppressed.
- Flush handling:
  - flush in FILL with (cnt>0 or a pop this cycle): the popped word, if any, is included first.
    - If the resulting count is RATIO, this is a normal full emit and flush is consumed.
    - Otherwise, if free: partial emit this edge, with out_count = resulting count and unused lanes zero.
    - Otherwise: go to FLUSH.
  - FLUSH: when free, emit the partial word, clear cnt and the accumulator, and return to FILL.
  - flush with cnt==0 and no pop: ignored, no output.
  - flush while in FLUSH: ignored.
- Reset mid-operation: all state is discarded immediately, including a partial word or a pending output. The FIFO is not popped while rst=1.
- Widths:
  - cnt is $clog2(RATIO) bits.
  - out_count is zero-extended.
  - No arithmetic beyond the counter increment, and the counter never wraps past RATIO-1.

Decomposition:
- Package fifo_drain_packer_pkg:
  - state enum {FILL, FLUSH}.
  - Function returning the lane bit offset for a given cnt, IN_WIDTH, RATIO and LSB_FIRST.
  - Localparam OUT_WIDTH = IN_WIDTH*RATIO.
- One natural sub-module: fifo_drain_packer_out_slice, the registered valid/ready output slot with load/hold/accept logic.
- Packing, counter and FSM stay in the top module.

Test Plan:
- Reset with FIFO empty:
  - Release rst, keep fifo_empty=1 for 10 cycles.
  - Expect fifo_pop_req_n=1 throughout, out_valid=0, out_data=0.
- Full pack, LSB_FIRST=1:
  - Push 0x11,0x22,0x33,0x44 into the FIFO, out_ready=1.
  - Expect 4 consecutive pops and out_data=0x44332211, out_count=4, with out_valid high for one cycle, the cycle after the 4th pop.
- Backpressure:
  - 8 words queued, out_ready=0.
  - Expect exactly 7 pops, then fifo_pop_req_n stays 1.
  - out_data=first word, stable.
  - Raise out_ready: the 8th pop occurs in the same cycle as the accept and the second word appears next cycle.
- Flush partial:
  - Pop 0xAA,0xBB, then pulse flush with the FIFO empty.
  - Expect out_data=0x0000BBAA, out_count=2, cnt back to 0.
- Flush blocked and flush coincident with a pop:
  - Output slot held (out_ready=0), pulse flush with 1 word packed: FSM enters FLUSH, no pops, emits after out_ready rises.
  - Separately, flush coincident with the 3rd pop gives out_count=3.
- Async reset mid-pack:
  - Assert rst between the 2nd and 3rd pop.
  - Expect out_valid=0 and fifo_pop_req_n=1 immediately.
  - After release, the next 4 words pack cleanly with no residue from before the reset.

Source files
------------

// File: rtl/fifo_drain_packer_pkg.sv
// Shared types and helpers for the FIFO drain packer.
// Holds the packer state enum and the lane placement rule.
package fifo_drain_packer_pkg;

    localparam int DEF_IN_WIDTH = 8;
    localparam int DEF_RATIO    = 4;
    localparam int OUT_WIDTH    = DEF_IN_WIDTH * DEF_RATIO;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Bit offset of lane `cnt` inside the packed word.
    function automatic int lane_offset(
        input int cnt,
        input int in_width,
        input int ratio,
        input bit lsb_first
    );
        if (lsb_first) begin
            return cnt * in_width;
        end
        return (ratio - 1 - cnt) * in_width;
    endfunction

endpackage

// File: rtl/fifo_drain_packer_out_slice.sv
// Registered valid/ready output slot of the packer.
// Loads a new word, holds it under backpressure, drops it on accept.
module fifo_drain_packer_out_slice
    import fifo_drain_packer_pkg::*;
#(
    parameter int W     = OUT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count
);

    // Slot register: a load wins over an accept, data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_drain_packer.sv
// Drains narrow words from a FIFO and packs RATIO of them per output.
// Flush emits a partial word, waiting in FLUSH if the slot is busy.
module fifo_drain_packer
    import fifo_drain_packer_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int RATIO     = DEF_RATIO,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [IN_WIDTH-1:0]          fifo_data,
    output logic                         fifo_pop_req_n,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_WIDTH*RATIO-1:0]    out_data,
    output logic [$clog2(RATIO+1)-1:0]   out_count
);

    localparam int OW = IN_WIDTH * RATIO;
    localparam int CW = $clog2(RATIO);
    localparam int NW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
    localparam logic [NW-1:0] FULL = NW'(RATIO);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [OW-1:0] acc, acc_n, merged, load_data;
    logic [NW-1:0] load_count, fill_count;
    logic          free, last, pop, load;

    // Pop decision: never while in reset, empty, flushing or blocked.
    always_comb begin
        free    = !out_valid || out_ready;
        last    = (cnt == LAST);
        pop     = !rst && (state == FILL) && !fifo_empty && (!last || free);
        cnt_inc = cnt + CW'(1);
    end

    assign fifo_pop_req_n = ~pop;

    // Accumulator with the word popped this cycle dropped into lane cnt.
    always_comb begin
        merged = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (pop && cnt == CW'(i)) begin
                merged[lane_offset(i, IN_WIDTH, RATIO, LSB_FIRST) +: IN_WIDTH] = fifo_data;
            end
        end
        fill_count = pop ? NW'(cnt_inc) : NW'(cnt);
    end

    // Next state, counter, accumulator and output load request.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        load       = 1'b0;
        load_data  = merged;
        load_count = '0;
        unique case (state)
            FILL: begin
                if (pop && last) begin
                    load       = 1'b1;
                    load_count = FULL;
                    cnt_n      = '0;
                    acc_n      = '0;
                end else if (flush && (cnt != '0 || pop)) begin
                    if (free) begin
                        load       = 1'b1;
                        load_count = fill_count;
                        cnt_n      = '0;
                        acc_n      = '0;
                    end else begin
                        state_n = FLUSH;
                        acc_n   = merged;
                        cnt_n   = pop ? cnt_inc : cnt;
                    end
                end else if (pop) begin
                    acc_n = merged;
                    cnt_n = cnt_inc;
                end
            end
            FLUSH: begin
                if (free) begin
                    load       = 1'b1;
                    load_data  = acc;
                    load_count = NW'(cnt);
                    cnt_n      = '0;
                    acc_n      = '0;
                    state_n    = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    fifo_drain_packer_out_slice #(
        .W     (OW),
        .CNT_W (NW)
    ) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count)
    );

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed plus randomized bench for fifo_drain_packer.
// A FIFO model feeds the DUT; expected words are packed from pushed words.
module tb_fifo_drain_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;
    localparam int NW = 3;
    localparam bit LSBF = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [IW-1:0] fifo_data;
    logic          fifo_pop_req_n;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [NW-1:0] out_count;

    logic [IW-1:0] mem [0:1023];
    int            wr = 0;
    int            rd = 0;
    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] pend [$];
    logic [OW-1:0] got [$];
    logic [OW-1:0] expq [$];

    logic          hold = 1'b0;
    logic [OW-1:0] hdata;
    logic [NW-1:0] hcount;

    always #5 clk = ~clk;

    assign fifo_empty = (rd == wr);
    assign fifo_data  = mem[rd[9:0]];

    fifo_drain_packer #(
        .IN_WIDTH  (IW),
        .RATIO     (R),
        .LSB_FIRST (LSBF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_pop_req_n (fifo_pop_req_n),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count)
    );

    // FIFO model: head advances on a pop request seen at the edge.
    always @(posedge clk) begin
        if (!rst && !fifo_pop_req_n && rd != wr) rd <= rd + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] w);
        mem[wr[9:0]] = w;
        wr = wr + 1;
        pend.push_back(w);
    endtask

    // Pack the n oldest pushed words: word i goes to lane i (or mirrored).
    task automatic take(input int n, output logic [OW-1:0] v);
        int lane;
        v = '0;
        for (int i = 0; i < n; i++) begin
            lane = LSBF ? i : R - 1 - i;
            if (pend.size() > 0) v = v | (OW'(pend.pop_front()) << (IW * lane));
        end
    endtask

    // Monitor just before each rising edge: invariants and accepted words.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            chk("rst_pop_n", 64'(fifo_pop_req_n), 64'd1);
            hold = 1'b0;
        end else begin
            chk("no_underflow", 64'(fifo_empty && !fifo_pop_req_n), 64'd0);
            if (hold && out_valid) begin
                chk("hold_data", 64'(out_data), 64'(hdata));
                chk("hold_count", 64'(out_count), 64'(hcount));
            end
            if (out_valid && out_ready) got.push_back(out_data);
            hold   = out_valid && !out_ready;
            hdata  = out_data;
            hcount = out_count;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] e, ea;
        int base, npush;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_pop_n", 64'(fifo_pop_req_n), 64'd1);
            chk("idle_valid", 64'(out_valid), 64'd0);
        end
        chk("idle_data", 64'(out_data), 64'd0);

        // Full pack of four known words.
        out_ready = 1'b1;
        @(negedge clk);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("full_pop", 64'(fifo_pop_req_n), 64'd0);
            chk("full_novalid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        take(4, e);
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_data", 64'(out_data), 64'h44332211);
        chk("full_data_model", 64'(out_data), 64'(e));
        chk("full_count", 64'(out_count), 64'd4);
        @(negedge clk);
        chk("full_valid_drop", 64'(out_valid), 64'd0);

        // Backpressure: seven pops, then the eighth coincides with accept.
        out_ready = 1'b0;
        base = rd;
        for (int i = 0; i < 8; i++) push(IW'($urandom));
        repeat (12) @(negedge clk);
        take(4, e);
        chk("bp_pops", 64'(rd - base), 64'd7);
        chk("bp_pop_n", 64'(fifo_pop_req_n), 64'd1);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data1", 64'(out_data), 64'(e));
        out_ready = 1'b1;
        #1;
        chk("bp_pop8", 64'(fifo_pop_req_n), 64'd0);
        @(negedge clk);
        take(4, e);
        chk("bp_valid2", 64'(out_valid), 64'd1);
        chk("bp_data2", 64'(out_data), 64'(e));
        chk("bp_pops8", 64'(rd - base), 64'd8);
        @(negedge clk);
        chk("bp_drop", 64'(out_valid), 64'd0);

        // Flush of a two-word partial.
        push(8'hAA); push(8'hBB);
        repeat (3) @(negedge clk);
        chk("fl_novalid", 64'(out_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        take(2, e);
        chk("fl_valid", 64'(out_valid), 64'd1);
        chk("fl_data", 64'(out_data), 64'h0000BBAA);
        chk("fl_data_model", 64'(out_data), 64'(e));
        chk("fl_count", 64'(out_count), 64'd2);
        @(negedge clk);
        chk("fl_drop", 64'(out_valid), 64'd0);
        got.delete();
        for (int i = 0; i < 4; i++) push(IW'($urandom));
        repeat (6) @(negedge clk);
        take(4, e);
        chk("fl_after_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("fl_after_data", 64'(got[0]), 64'(e));

        // Flush while the slot is held, then flush with the 3rd pop.
        out_ready = 1'b0;
        base = rd;
        for (int i = 0; i < 5; i++) push(IW'($urandom));
        repeat (8) @(negedge clk);
        take(4, ea);
        chk("fb_pops", 64'(rd - base), 64'd5);
        chk("fb_data_held", 64'(out_data), 64'(ea));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        take(1, e);
        push(IW'($urandom));
        repeat (3) @(negedge clk);
        chk("fb_no_pop_n", 64'(fifo_pop_req_n), 64'd1);
        chk("fb_no_pops", 64'(rd - base), 64'd5);
        chk("fb_still", 64'(out_data), 64'(ea));
        out_ready = 1'b1;
        @(negedge clk);
        chk("fb_valid", 64'(out_valid), 64'd1);
        chk("fb_data", 64'(out_data), 64'(e));
        chk("fb_count", 64'(out_count), 64'd1);
        @(negedge clk);
        push(IW'($urandom));
        @(negedge clk);
        push(IW'($urandom));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        take(3, e);
        chk("fc_valid", 64'(out_valid), 64'd1);
        chk("fc_data", 64'(out_data), 64'(e));
        chk("fc_count", 64'(out_count), 64'd3);
        @(negedge clk);
        chk("fc_drop", 64'(out_valid), 64'd0);

        // Async reset with a pending output and a half-packed word.
        out_ready = 1'b0;
        base = rd;
        for (int i = 0; i < 8; i++) push(IW'($urandom));
        repeat (6) @(negedge clk);
        chk("ar_pops", 64'(rd - base), 64'd6);
        chk("ar_pending", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        chk("ar_pop_n", 64'(fifo_pop_req_n), 64'd1);
        take(4, e);
        take(2, e);
        @(negedge clk);
        chk("ar_no_pop", 64'(rd - base), 64'd6);
        got.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        push(IW'($urandom)); push(IW'($urandom));
        repeat (7) @(negedge clk);
        take(4, e);
        chk("ar_after_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("ar_after_data", 64'(got[0]), 64'(e));

        // Randomized traffic with random backpressure.
        got.delete();
        expq.delete();
        npush = 0;
        while (npush < 80) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push(IW'($urandom));
                npush++;
                if (npush % 4 == 0) begin
                    take(4, e);
                    expq.push_back(e);
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && got.size() < expq.size(); i++) @(negedge clk);
        chk("rand_n", 64'(got.size()), 64'(expq.size()));
        foreach (expq[i]) begin
            if (i < got.size()) chk("rand_data", 64'(got[i]), 64'(expq[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
